// File: rtl/i2s_rx_pkg.sv
// Shared I2S definitions: word-select levels, FSM encodings, small helpers.
package i2s_rx_pkg;

   // LRCK level meaning in Philips format
   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

   // Depth of the input synchronisers (all three pins see the same delay)
   localparam int SYNC_STAGES = 2;

   // Frame-alignment state, shared with the transmit side
   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } i2s_state_e;

   // A slot is short when it delivered fewer bits than one captured word
   function automatic logic is_short(input int bits_rx, input int word_size);
      return (bits_rx < word_size);
   endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Serial input pins and parallel sample outputs of the I2S receiver.
interface i2s_rx_if #(
   parameter int WORD_SIZE = 24
);
   logic                 i_bck;
   logic                 i_lrck;
   logic                 i_din;
   logic [WORD_SIZE-1:0] o_l_data;
   logic [WORD_SIZE-1:0] o_r_data;
   logic                 o_valid;
   logic                 o_short;

   // Source of the serial stream / consumer of the samples
   modport master (
      output i_bck, i_lrck, i_din,
      input  o_l_data, o_r_data, o_valid, o_short
   );

   // The receiver itself
   modport slave (
      input  i_bck, i_lrck, i_din,
      output o_l_data, o_r_data, o_valid, o_short
   );
endinterface

// File: rtl/i2s_rx_sync_edge.sv
// N-stage synchroniser with registered rise/fall pulses of the synchronised level.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   // Shift the pin through the chain and compare against the previous sample
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
      rise_d = sync_q[STAGES-1] & ~prev_q;
      fall_d = ~sync_q[STAGES-1] & prev_q;
   end

   // Synchroniser and edge-detect registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips) receiver: oversamples BCK/LRCK/DIN on i_clk, deserialises
// MSB-first slots and presents each completed L/R pair with a 1-cycle strobe.
module i2s_rx
   import i2s_rx_pkg::*;
#(
   parameter int WORD_SIZE = 24,
   parameter int SLOT_MAX  = 32
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   i2s_rx_if.slave bus
);

   localparam int CW = $clog2(SLOT_MAX + 1);
   localparam logic [WORD_SIZE-1:0] MSB_ONE = {1'b1, {(WORD_SIZE-1){1'b0}}};

   logic bck_rise;
   logic ws_s, din_s;
   logic bck_q_unused, bck_fall_unused;
   logic lrck_rise_unused, lrck_fall_unused;
   logic din_rise_unused, din_fall_unused;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bck (
      .clk(i_clk), .rst_n(i_rst_n), .d(bus.i_bck),
      .q(bck_q_unused), .rise(bck_rise), .fall(bck_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
      .clk(i_clk), .rst_n(i_rst_n), .d(bus.i_lrck),
      .q(ws_s), .rise(lrck_rise_unused), .fall(lrck_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
      .clk(i_clk), .rst_n(i_rst_n), .d(bus.i_din),
      .q(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
   );

   i2s_state_e           state_q, state_d;
   logic                 ws_prev_q, ws_prev_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WORD_SIZE-1:0] shreg_q, shreg_d;
   logic [WORD_SIZE-1:0] l_hold_q, l_hold_d;
   logic [WORD_SIZE-1:0] r_hold_q, r_hold_d;
   logic [WORD_SIZE-1:0] l_data_q, l_data_d;
   logic [WORD_SIZE-1:0] r_data_q, r_data_d;
   logic                 valid_q, valid_d;
   logic                 short_q, short_d;
   logic [WORD_SIZE-1:0] shreg_nx;

   // Per-bit-tick capture, slot close and frame-alignment FSM
   always_comb begin
      state_d   = state_q;
      ws_prev_d = ws_prev_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      l_hold_d  = l_hold_q;
      r_hold_d  = r_hold_q;
      l_data_d  = l_data_q;
      r_data_d  = r_data_q;
      valid_d   = 1'b0;
      short_d   = short_q;

      // Shift register with the current bit merged in; bits past the word are dropped
      shreg_nx = shreg_q;
      if ((cnt_q < CW'(WORD_SIZE)) && din_s)
         shreg_nx = shreg_q | (MSB_ONE >> cnt_q);

      if (bck_rise) begin
         ws_prev_d = ws_s;
         if (ws_s != ws_prev_q) begin
            // The bit at an LRCK change is the LSB of the slot that just ended
            shreg_d = '0;
            cnt_d   = '0;
            if (state_q != ST_HUNT) begin
               if (ws_prev_q == WS_LEFT) l_hold_d = shreg_nx;
               else                      r_hold_d = shreg_nx;
               if (is_short(int'(cnt_q) + 1, WORD_SIZE)) short_d = 1'b1;
            end
            case (state_q)
               ST_HUNT: state_d = ST_SYNC;
               ST_SYNC: state_d = ST_RUN;
               ST_RUN: begin
                  if (ws_prev_q == WS_RIGHT) begin
                     valid_d  = 1'b1;
                     l_data_d = l_hold_q;
                     r_data_d = shreg_nx;
                  end
               end
               default: state_d = ST_HUNT;
            endcase
         end else begin
            shreg_d = shreg_nx;
            if (cnt_q != CW'(SLOT_MAX)) cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_HUNT;
         ws_prev_q <= 1'b0;
         cnt_q     <= '0;
         shreg_q   <= '0;
         l_hold_q  <= '0;
         r_hold_q  <= '0;
         l_data_q  <= '0;
         r_data_q  <= '0;
         valid_q   <= 1'b0;
         short_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ws_prev_q <= ws_prev_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         l_hold_q  <= l_hold_d;
         r_hold_q  <= r_hold_d;
         l_data_q  <= l_data_d;
         r_data_q  <= r_data_d;
         valid_q   <= valid_d;
         short_q   <= short_d;
      end
   end

   assign bus.o_l_data = l_data_q;
   assign bus.o_r_data = r_data_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_short  = short_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives Philips-format frames, checks words,
// strobe count/latency, short-slot flag, async reset and BCK stall.
module tb_i2s_rx;

   localparam int WS = 24;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   i2s_rx_if #(.WORD_SIZE(WS)) bus ();

   i2s_rx #(.WORD_SIZE(WS), .SLOT_MAX(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int rise_cyc = 0;
   int vcnt   = 0;
   int lo_c   = 4;
   int hi_c   = 4;
   bit jit    = 0;
   bit lat_en = 1;
   logic pend = 1'b0;
   logic [WS-1:0] exp_l[$];
   logic [WS-1:0] exp_r[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [WS-1:0] exp_word(input logic [31:0] w, input int nb);
      logic [31:0] t;
      t = w << (WS - nb);
      return t[WS-1:0];
   endfunction

   // One BCK period: data/LRCK change while BCK is low, sampled on the rise
   task automatic send_bit(input logic ws, input logic b);
      @(negedge clk);
      if (jit) #($urandom_range(1, 3));
      bus.i_bck = 1'b0; bus.i_lrck = ws; bus.i_din = b;
      repeat (lo_c) @(negedge clk);
      if (jit) #($urandom_range(1, 3));
      bus.i_bck = 1'b1; rise_cyc = cyc;
      repeat (hi_c - 1) @(negedge clk);
   endtask

   // First tick of a slot carries the previous slot's LSB
   task automatic send_slot(input logic ws, input logic [31:0] w, input int nb,
                            input int s, input int stall);
      send_bit(ws, pend);
      for (int i = 1; i < s; i++) begin
         if (i == stall) repeat (500) @(negedge clk);
         send_bit(ws, (i - 1 < nb) ? w[nb - i] : 1'b0);
      end
      pend = (s - 1 < nb) ? w[nb - s] : 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nb,
                             input int s, input bit push);
      send_slot(1'b0, l, nb, s, -1);
      send_slot(1'b1, r, nb, s, -1);
      if (push) begin
         exp_l.push_back(exp_word(l, nb));
         exp_r.push_back(exp_word(r, nb));
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Strobe monitor: each valid cycle consumes exactly one expected pair
   initial forever begin
      @(negedge clk);
      if (rst_n && bus.o_valid) begin
         vcnt++;
         if (lat_en) check("latency", 32'(cyc - rise_cyc), 32'd4);
         if (exp_l.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
         else begin
            check("l_data", 32'(bus.o_l_data), 32'(exp_l.pop_front()));
            check("r_data", 32'(bus.o_r_data), 32'(exp_r.pop_front()));
         end
      end
   end

   initial begin
      logic [31:0] rl, rr;
      int v0;
      bus.i_bck = 1'b0; bus.i_lrck = 1'b0; bus.i_din = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_l_data", 32'(bus.o_l_data), 32'd0);
      check("rst_r_data", 32'(bus.o_r_data), 32'd0);
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_short", 32'(bus.o_short), 32'd0);
      rst_n = 1'b1;

      // 32-bit slots, BCK = clk/8: first pair only after the second full frame
      send_frame(32'hA5A5A5, 32'h5A5A5A, 24, 32, 0);
      send_frame(32'hA5A5A5, 32'h5A5A5A, 24, 32, 1);
      repeat (8) @(negedge clk);
      check("t1_no_early_valid", 32'(vcnt), 32'd0);
      send_frame(32'hA5A5A5, 32'h5A5A5A, 24, 32, 1);
      send_frame(32'hA5A5A5, 32'h5A5A5A, 24, 32, 1);
      repeat (8) @(negedge clk);
      check("t1_valid_count", 32'(vcnt), 32'd2);

      // 24-bit back-to-back slots with extreme patterns
      for (int f = 0; f < 4; f++) send_frame(32'h800001, 32'h7FFFFE, 24, 24, 1);
      repeat (8) @(negedge clk);
      check("t2_pending", 32'(exp_l.size()), 32'd1);
      check("t2_short", 32'(bus.o_short), 32'd0);

      // 16-bit slots: LSBs zero-filled, sticky short flag
      send_frame(32'hFFFF, 32'h1234, 16, 16, 1);
      send_frame(32'hFFFF, 32'h1234, 16, 16, 1);
      repeat (8) @(negedge clk);
      check("t3_short_set", 32'(bus.o_short), 32'd1);
      check("t3_l_fill", 32'(bus.o_l_data), 32'hFFFF00);
      send_frame(32'h123456, 32'h654321, 24, 24, 1);
      send_frame(32'h0F0F0F, 32'hF0F0F0, 24, 24, 1);
      repeat (8) @(negedge clk);
      check("t3_short_sticky", 32'(bus.o_short), 32'd1);

      // Reset in the middle of a right slot
      send_slot(1'b0, 32'hABCDEF, 24, 24, -1);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t4_l_zero", 32'(bus.o_l_data), 32'd0);
      check("t4_r_zero", 32'(bus.o_r_data), 32'd0);
      check("t4_short_zero", 32'(bus.o_short), 32'd0);
      exp_l.delete(); exp_r.delete();
      bus.i_bck = 1'b0; bus.i_lrck = 1'b0; bus.i_din = 1'b0; pend = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      v0 = vcnt;
      send_frame(32'h111111, 32'h222222, 24, 24, 0);
      send_frame(32'h333333, 32'h444444, 24, 24, 1);
      repeat (8) @(negedge clk);
      check("t4_no_valid_resync", 32'(vcnt - v0), 32'd0);
      send_frame(32'h555555, 32'h666666, 24, 24, 1);
      repeat (8) @(negedge clk);
      check("t4_first_after_rst", 32'(vcnt - v0), 32'd1);

      // Random data at BCK = clk/4 and clk/13 with sub-cycle phase jitter
      lat_en = 0; jit = 1;
      lo_c = 2; hi_c = 2;
      for (int f = 0; f < 30; f++) begin
         rl = $urandom() & 32'hFFFFFF; rr = $urandom() & 32'hFFFFFF;
         send_frame(rl, rr, 24, 24, 1);
      end
      lo_c = 6; hi_c = 7;
      for (int f = 0; f < 15; f++) begin
         rl = $urandom() & 32'hFFFFFF; rr = $urandom() & 32'hFFFFFF;
         send_frame(rl, rr, 24, 24, 1);
      end

      // BCK stalls for 500 cycles inside a right slot
      jit = 0; lo_c = 4; hi_c = 4;
      send_slot(1'b0, 32'hC3C3C3, 24, 24, -1);
      repeat (8) @(negedge clk);
      lat_en = 1;
      v0 = vcnt;
      send_slot(1'b1, 32'h3C3C3C, 24, 24, 10);
      exp_l.push_back(24'hC3C3C3); exp_r.push_back(24'h3C3C3C);
      check("t6_no_spurious", 32'(vcnt - v0), 32'd0);
      send_frame(32'h0000FF, 32'hFF0000, 24, 24, 1);
      send_bit(1'b0, pend);
      repeat (10) @(negedge clk);
      check("t6_all_delivered", 32'(exp_l.size()), 32'd0);
      check("t6_l_hold", 32'(bus.o_l_data), 32'h0000FF);
      check("t6_r_hold", 32'(bus.o_r_data), 32'hFF0000);
      check("t6_short_clear", 32'(bus.o_short), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
